seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Parametrised multi-cycle restoring divider, one quotient bit per clock. It is the successor of the team's fixed 32-bit unsigned divider. New over that block:
- WIDTH parameter
- per-operation signed/unsigned mode
- explicit start/busy/done handshake
- synchronous active-low reset
- divide-by-zero and signed-overflow flags
It sits beside the ALU and serves DIV/REM-class instructions for the CPU datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).
- SIGNED_EN, 1, 1 = honour is_signed; 0 = is_signed ignored, always unsigned; sign logic removed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  two's-complement operation when 1 (and SIGNED_EN=1)
- dividend  input  WIDTH  captured on accepted start
- divisor  input  WIDTH  captured on accepted start
- busy  output  1  high from accept edge until done is asserted
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  registered, held until next accepted start
- remainder  output  WIDTH  registered, held until next accepted start
- div_by_zero  output  1  registered with results
- overflow  output  1  signed MIN / -1; registered with results

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; sampled only at the rising edge.
- Reset values: state=IDLE; busy=0; done=0; quotient=0; remainder=0; div_by_zero=0; overflow=0; internal counter=0.
- Reset mid-operation: abandon the operation; everything returns to reset values at that edge; no done pulse.
- States: IDLE, CALC, FIXUP.
- IDLE -> CALC: on edge with start=1 and divisor!=0.
  - Capture magnitudes |dividend| and |divisor| (signed mode) or raw values.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Clear partial remainder (WIDTH+1 bits) and quotient shift register; load counter=WIDTH; busy=1.
- IDLE -> FIXUP: on start with divisor==0; no CALC iterations.
- CALC, one iteration per edge:
  - Shift {partial_rem, dividend_shift} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Decrement counter. When the counter reaches 0 after this edge, go to FIXUP.
- FIXUP, single edge:
  - Register quotient = neg_q ? -q_mag : q_mag and remainder = neg_r ? -r_mag : r_mag, truncated to WIDTH.
  - Set done=1 for exactly the following cycle; busy=0; go to IDLE.
- Divide-by-zero result: quotient = all ones; remainder = dividend unchanged; div_by_zero=1; sign fixup not applied.
- Signed overflow: dividend = 1 followed by WIDTH-1 zeros, divisor = all ones, signed mode. Result quotient = dividend, remainder = 0, overflow=1. This falls out of magnitude arithmetic; the flag is decoded at capture.
- Latency:
  - Normal: done is high in the cycle after edge WIDTH+1 counted from the accepting edge (edge 0).
  - Divide-by-zero: done is high after edge 1.
  - Throughput: a new start is accepted in the done cycle (state is IDLE), so back-to-back operations take WIDTH+2 cycles each.
- Start while busy: ignored; no queuing; captured operands and results unaffected.
- Operand changes after the accept edge: no effect.
- Flag lifetime: both flags are cleared at the next accepted start.
- Remainder sign: follows the dividend; quotient truncates toward zero. Invariant: dividend = quotient*divisor + remainder (mod 2^WIDTH).
- No combinational path from inputs to outputs.

Decomposition:
- Package div_pkg:
  - state enum (IDLE, CALC, FIXUP)
  - CNT_W = $clog2(WIDTH+1) as a parameterised localparam pattern
  - helper function for two's-complement negate/abs
- Sub-module div_step (combinational, one shift/trial-subtract/select stage, WIDTH-parametrised) keeps the iteration unit-testable. Everything else stays in seq_divider.

Test Plan:
1. Unsigned 100/7, WIDTH=32 -> quotient=14, remainder=2, flags 0; done exactly 33 edges after accept, busy high for those cycles.
2. Signed -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); signed 7/-2 -> quotient=-3, remainder=1.
3. 5/0, either mode -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; done after 1 edge.
4. Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1. Same operands unsigned -> quotient=0, remainder=0x80000000, overflow=0.
5. Unsigned 0xFFFFFFFF/0xFFFFFFFF -> quotient=1, remainder=0. Then start pulsed every cycle while busy -> exactly one done per WIDTH+2 cycles; results match the first operands only.
6. rst_n=0 for one edge at CALC iteration 10 -> next cycle busy=0, done=0, outputs 0; no done pulse later. Also WIDTH=8, SIGNED_EN=0: 200/3 -> quotient=66, remainder=2, done after 9 edges.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared divider states, counter sizing and two's-complement helper
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
  localparam int MAX_W = 64;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring step (rem,dsh,dvs -> rem_n,dsh_n), shifts {rem,dsh} left, trial-subtracts dvs, shifts quotient bit into dsh
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dsh,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_n,
  output logic [WIDTH-1:0] dsh_n
);
  logic [WIDTH+1:0] sh, trial;
  always_comb begin
    sh    = {rem, dsh[WIDTH-1]};
    trial = sh - {2'b00, dvs};
    rem_n = (WIDTH+1)'(trial[WIDTH+1] ? sh : trial);
    dsh_n = {dsh[WIDTH-2:0], ~trial[WIDTH+1]};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed/unsigned restoring divider (clk,rst_n,start,is_signed,dividend,divisor -> busy,done,quotient,remainder,div_by_zero,overflow)
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CNT_W = cnt_w(WIDTH);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem, rem_n;
  logic [WIDTH-1:0] dsh, dsh_n, dvs;
  logic             neg_q, neg_r, dbz_r, ovf_r;
  logic             sgn, dz, ovf;
  always_comb begin
    sgn = SIGNED_EN && is_signed;
    dz  = divisor == '0;
    ovf = sgn && dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1;
  end
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem),
    .dsh   (dsh),
    .dvs   (dvs),
    .rem_n (rem_n),
    .dsh_n (dsh_n)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dsh         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy        <= 1'b1;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          rem         <= '0;
          cnt         <= CNT_W'(WIDTH);
          dbz_r       <= dz;
          ovf_r       <= ovf;
          neg_q       <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r       <= sgn & dividend[WIDTH-1];
          dsh         <= dz ? dividend : WIDTH'(cond_neg(MAX_W'(dividend), sgn & dividend[WIDTH-1]));
          dvs         <= WIDTH'(cond_neg(MAX_W'(divisor), sgn & divisor[WIDTH-1]));
          state       <= dz ? FIXUP : CALC;
        end
        CALC: begin
          rem <= rem_n;
          dsh <= dsh_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIXUP;
        end
        FIXUP: begin
          quotient    <= dbz_r ? '1 : WIDTH'(cond_neg(MAX_W'(dsh), neg_q));
          remainder   <= dbz_r ? dsh : WIDTH'(cond_neg(MAX_W'(rem[WIDTH-1:0]), neg_r));
          div_by_zero <= dbz_r;
          overflow    <= ovf_r;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed tests with a queue-based reference model for seq_divider
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, is_signed = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;
  logic        start8 = 1'b0, is_signed8 = 1'b0;
  logic [7:0]  dividend8 = '0, divisor8 = '0;
  logic        busy8, done8, dz8, ov8;
  logic [7:0]  quotient8, remainder8;
  int total = 0, bad = 0;
  int cyc = 0, last_acc = 0, last_done = 0, prev_done = 0, n_done = 0;
  bit armed = 0;
  typedef struct {logic [31:0] q, r; logic dz, ov; int due;} exp_t;
  exp_t pend[$];

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32), .SIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );
  seq_divider #(.WIDTH(8), .SIGNED_EN(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(is_signed8),
    .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(dz8), .overflow(ov8)
  );

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    exp_t e;
    longint sa, sd;
    e.dz = (b == 0);
    e.ov = 1'b0;
    e.due = 0;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (sg) begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      e.q = 32'(sa / sd);
      e.r = 32'(sa % sd);
      e.ov = (sa == -64'sd2147483648) && (sd == -64'sd1);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) pend.delete();
    else if (start && pend.size() == 0) begin
      e = model(dividend, divisor, is_signed);
      e.due = cyc + (divisor == 0 ? 1 : 33);
      last_acc = cyc;
      pend.push_back(e);
    end
  end

  always @(negedge clk) begin
    logic eb, ed;
    if (armed) begin
      eb = pend.size() != 0 && cyc < pend[0].due;
      ed = pend.size() != 0 && cyc == pend[0].due;
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      if (ed) begin
        chk("quotient", quotient, pend[0].q);
        chk("remainder", remainder, pend[0].r);
        chk("div_by_zero", 32'(div_by_zero), 32'(pend[0].dz));
        chk("overflow", 32'(overflow), 32'(pend[0].ov));
        prev_done = last_done;
        last_done = cyc;
        n_done++;
        void'(pend.pop_front());
      end else if (pend.size() != 0 && cyc > pend[0].due) void'(pend.pop_front());
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && pend.size() != 0; i++) @(negedge clk);
    chk("timeout", 32'(pend.size()), 0);
    @(negedge clk);
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic sg);
    @(negedge clk);
    dividend = a;
    divisor = b;
    is_signed = sg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    is_signed = ~sg;
    wait_idle();
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sg, input logic [7:0] eq, input logic [7:0] er);
    int n;
    @(negedge clk);
    dividend8 = a;
    divisor8 = b;
    is_signed8 = sg;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dividend8 = 8'h5A;
    chk("w8 busy", 32'(busy8), 1);
    n = 0;
    while (!done8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w8 latency", n, 9);
    chk("w8 quotient", 32'(quotient8), 32'(eq));
    chk("w8 remainder", 32'(remainder8), 32'(er));
    chk("w8 flags", {30'd0, dz8, ov8}, 0);
  endtask

  initial begin
    int nd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    armed = 1;
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    chk("rst flags", {30'd0, div_by_zero, overflow}, 0);
    chk("rst busy/done", {30'd0, busy, done}, 0);

    go(32'd100, 32'd7, 1'b0);
    chk("100/7 q", quotient, 14);
    chk("100/7 r", remainder, 2);
    chk("100/7 latency", last_done - last_acc, 33);
    go(-32'sd7, 32'd2, 1'b1);
    chk("-7/2 q", quotient, 32'hFFFF_FFFD);
    chk("-7/2 r", remainder, 32'hFFFF_FFFF);
    go(32'd7, -32'sd2, 1'b1);
    chk("7/-2 q", quotient, 32'hFFFF_FFFD);
    chk("7/-2 r", remainder, 1);
    go(32'd5, 32'd0, 1'b0);
    chk("5/0u q", quotient, 32'hFFFF_FFFF);
    chk("5/0u r", remainder, 5);
    chk("5/0u dz", 32'(div_by_zero), 1);
    chk("5/0u latency", last_done - last_acc, 1);
    go(32'd5, 32'd0, 1'b1);
    chk("5/0s r", remainder, 5);
    chk("5/0s dz", 32'(div_by_zero), 1);
    go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("min/-1 q", quotient, 32'h8000_0000);
    chk("min/-1 r", remainder, 0);
    chk("min/-1 flags", {30'd0, div_by_zero, overflow}, 1);
    go(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("min/-1u q", quotient, 0);
    chk("min/-1u r", remainder, 32'h8000_0000);
    chk("min/-1u ov", 32'(overflow), 0);
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("max/max q", quotient, 1);
    chk("max/max r", remainder, 0);

    nd0 = n_done;
    @(negedge clk);
    dividend = 32'd1000;
    divisor = 32'd10;
    is_signed = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 68; i++) begin
      @(negedge clk);
      if (i == 0) chk("b2b first busy", 32'(busy), 1);
      dividend = $urandom;
      divisor = $urandom_range(32'hFFFF, 1);
      is_signed = 1'($urandom);
    end
    start = 1'b0;
    wait_idle();
    chk("b2b done count", n_done - nd0, 2);
    chk("b2b done spacing", last_done - prev_done, 34);

    go(32'd1000, 32'd10, 1'b0);
    chk("1000/10 q", quotient, 100);
    nd0 = n_done;
    @(negedge clk);
    dividend = 32'd100;
    divisor = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst busy/done", {30'd0, busy, done}, 0);
    chk("midrst quotient", quotient, 0);
    chk("midrst remainder", remainder, 0);
    chk("midrst flags", {30'd0, div_by_zero, overflow}, 0);
    repeat (40) @(negedge clk);
    chk("midrst no done", n_done - nd0, 0);
    chk("midrst held q", quotient, 0);

    go8(8'd200, 8'd3, 1'b0, 8'd66, 8'd2);
    go8(8'd200, 8'd3, 1'b1, 8'd66, 8'd2);
    go8(8'd255, 8'd16, 1'b1, 8'd15, 8'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
